uart_receiver: RTL and testbench

- 8N1 UART receiver; the far-end consumer of the serial line driven by the team's transmitter (`udata`).
- Idle-high line, start bit 0, 8 data bits LSB first, stop bit 1, nominal 9600 baud on the 50 MHz clock.
- Oversamples the asynchronous line 16x, majority-votes each bit at mid-bit, and presents each byte with a one-cycle valid pulse.
- Flags framing errors and rejects start-bit glitches.

---
 rtl/uart_pkg.sv | 33 +++
 rtl/uart_receiver_baud_tick_gen.sv | 35 +++
 rtl/uart_receiver.sv | 143 ++++++++++++++
 tb/tb_uart_receiver.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants, state encoding and helpers for the 8N1 UART receive path.
// DIV is always derived from CLK_FREQ and BAUD, never set directly.
package uart_pkg;

  localparam int unsigned CLK_FREQ   = 50_000_000;
  localparam int unsigned BAUD       = 9600;
  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned DIV        = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int unsigned DATA_BITS  = 8;

  // Oversample tick indices voted at the middle of every bit.
  localparam logic [3:0] SAMPLE_A = 4'd7;
  localparam logic [3:0] SAMPLE_B = 4'd8;
  localparam logic [3:0] SAMPLE_C = 4'd9;

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_e;

  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned baud);
    return clk_freq / (baud * OVERSAMPLE);
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_receiver_baud_tick_gen.sv
// Oversample tick generator: counts 0..TICK_DIV-1 and asserts tick_o on the last count.
// clr_i restarts the count synchronously so a frame's ticks line up with its start edge.
module baud_tick_gen import uart_pkg::*; #(
  parameter int unsigned TICK_DIV = DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr_i || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == LAST) && !clr_i;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: 2-flop synchronizer, 16x oversampling, 3-sample majority vote
// at mid-bit, one-cycle valid / framing_error pulses.
//
// state     | meaning
// WAIT_IDLE | after reset or a bad stop bit: need 16 consecutive high ticks
// IDLE      | line idle, waiting for the first low sample (start detect)
// START     | checking the start bit at ticks 7/8/9; high majority = glitch
// DATA      | shifting in 8 data bits, LSB first
// STOP      | checking the stop bit at tick 153
module uart_receiver import uart_pkg::*; #(
  parameter int unsigned CLK_FREQ = uart_pkg::CLK_FREQ,
  parameter int unsigned BAUD     = uart_pkg::BAUD
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       udata,
  output logic [7:0] out,
  output logic       valid,
  output logic       framing_error,
  output logic       busy
);

  localparam int unsigned TICK_DIV = calc_div(CLK_FREQ, BAUD);
  localparam logic [3:0]  OS_LAST  = 4'(OVERSAMPLE - 1);
  localparam logic [2:0]  BIT_LAST = 3'(DATA_BITS - 1);

  logic [1:0]           sync_q;
  logic                 rx;
  rx_state_e            state_q;
  logic [3:0]           os_q;
  logic [3:0]           os_d;
  logic [3:0]           idle_cnt_q;
  logic [2:0]           bit_cnt_q;
  logic [1:0]           samp_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] out_q;
  logic                 valid_q;
  logic                 ferr_q;
  logic                 tick;
  logic                 start_det;
  logic                 decide;
  logic                 vote;

  assign rx        = sync_q[1];
  assign start_det = (state_q == IDLE) && !rx;
  assign os_d      = os_q + 4'd1;
  // os_d is the index of the tick firing this cycle, counted from the start edge.
  assign decide    = tick && (os_d == SAMPLE_C);
  assign vote      = maj3(samp_q[0], samp_q[1], rx);

  baud_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (start_det),
    .tick_o (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= 2'b11;
      state_q    <= WAIT_IDLE;
      os_q       <= '0;
      idle_cnt_q <= '0;
      bit_cnt_q  <= '0;
      samp_q     <= '0;
      shift_q    <= '0;
      out_q      <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], udata};
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;

      if (start_det) begin
        os_q <= '0;
      end else if (tick) begin
        os_q <= os_d;
      end

      if (tick && (os_d == SAMPLE_A)) samp_q[0] <= rx;
      if (tick && (os_d == SAMPLE_B)) samp_q[1] <= rx;

      case (state_q)
        WAIT_IDLE: begin
          if (!rx) begin
            idle_cnt_q <= '0;
          end else if (tick) begin
            if (idle_cnt_q == OS_LAST) begin
              idle_cnt_q <= '0;
              state_q    <= IDLE;
            end else begin
              idle_cnt_q <= idle_cnt_q + 4'd1;
            end
          end
        end
        IDLE: begin
          if (start_det) begin
            bit_cnt_q <= '0;
            state_q   <= START;
          end
        end
        START: begin
          if (decide) begin
            state_q <= vote ? IDLE : DATA;
          end
        end
        DATA: begin
          if (decide) begin
            shift_q   <= {vote, shift_q[DATA_BITS-1:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == BIT_LAST) begin
              state_q <= STOP;
            end
          end
        end
        STOP: begin
          if (decide) begin
            if (vote) begin
              out_q   <= shift_q;
              valid_q <= 1'b1;
              state_q <= IDLE;
            end else begin
              // A low stop bit may be the middle of someone else's frame: resync on idle.
              ferr_q     <= 1'b1;
              idle_cnt_q <= '0;
              state_q    <= WAIT_IDLE;
            end
          end
        end
        default: state_q <= WAIT_IDLE;
      endcase
    end
  end

  assign out           = out_q;
  assign valid         = valid_q;
  assign framing_error = ferr_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver, run with a small clock so DIV=10 (160-cycle bits).
module tb_uart_receiver;

  localparam int unsigned TB_BAUD = 9600;
  localparam int unsigned TB_DIV  = 10;
  localparam int unsigned TB_CLK  = TB_BAUD * 16 * TB_DIV;
  localparam int          BIT     = 16 * TB_DIV;
  localparam int          EXP_LAT = 153 * TB_DIV + 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       udata = 1'b1;
  logic [7:0] out;
  logic       valid;
  logic       framing_error;
  logic       busy;

  uart_receiver #(
    .CLK_FREQ(TB_CLK),
    .BAUD    (TB_BAUD)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .udata        (udata),
    .out          (out),
    .valid        (valid),
    .framing_error(framing_error),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         n_valid = 0;
  int         n_ferr = 0;
  int         n_both = 0;
  int         last_valid_cyc = 0;
  int         t_start = 0;
  logic [7:0] got_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid) begin
      n_valid++;
      got_q.push_back(out);
      last_valid_cyc = cyc;
    end
    if (framing_error) n_ferr++;
    if (valid && framing_error) n_both++;
  end

  typedef struct {
    logic [7:0] data;
    int         bl;
    logic       stop_b;
    logic       spike;
    int         exp_nvalid;
    int         exp_nferr;
    logic [7:0] exp_out;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [31:0] q_at(input int i);
    if (i < got_q.size()) return {24'h0, got_q[i]};
    return 32'hFFFF_FFFF;
  endfunction

  // Drives one frame starting at the current negedge; ends with the line high.
  task automatic send_frame(input logic [7:0] d, input int bl, input logic stop_b,
                            input logic spike);
    t_start = cyc;
    udata = 1'b0;
    wait_cyc(bl);
    for (int i = 0; i < 8; i++) begin
      udata = d[i];
      if (spike && i == 0) begin
        wait_cyc(bl / 2);
        udata = 1'b0;
        wait_cyc(1);
        udata = d[0];
        wait_cyc(bl - bl / 2 - 1);
      end else begin
        wait_cyc(bl);
      end
    end
    udata = stop_b;
    wait_cyc(bl);
    udata = 1'b1;
  endtask

  initial begin
    int         v0;
    int         f0;
    int         lat;
    int         exp_ferr;
    logic [7:0] model_out;
    logic [7:0] exp_q[$];

    vecs[0] = '{8'h11, 160, 1'b1, 1'b0, 1, 0, 8'h11};
    vecs[1] = '{8'h3C, 160, 1'b0, 1'b0, 0, 1, 8'h11};
    vecs[2] = '{8'hC3, 160, 1'b1, 1'b1, 1, 0, 8'hC3};
    vecs[3] = '{8'hC3, 157, 1'b1, 1'b1, 1, 0, 8'hC3};
    vecs[4] = '{8'hC3, 163, 1'b1, 1'b1, 1, 0, 8'hC3};
    vecs[5] = '{8'h96, 157, 1'b1, 1'b0, 1, 0, 8'h96};

    // Reset state and WAIT_IDLE exit
    wait_cyc(3);
    check("rst_out", out, 8'h00);
    check("rst_valid", valid, 1'b0);
    check("rst_ferr", framing_error, 1'b0);
    check("rst_busy", busy, 1'b1);
    rst_n = 1'b1;
    wait_cyc(2);
    check("wait_idle_busy", busy, 1'b1);
    wait_cyc(16 * BIT);
    check("idle_busy", busy, 1'b0);

    // Single frame with latency check
    v0 = n_valid; f0 = n_ferr;
    send_frame(8'hA5, 161, 1'b1, 1'b0);
    wait_cyc(BIT);
    check("a5_nvalid", n_valid - v0, 1);
    check("a5_out", out, 8'hA5);
    check("a5_nferr", n_ferr - f0, 0);
    lat = last_valid_cyc - t_start;
    check("a5_latency_in_window", (lat >= EXP_LAT - 2 && lat <= EXP_LAT + 2), 1'b1);

    // Back-to-back frames, no idle gap
    got_q.delete();
    v0 = n_valid; f0 = n_ferr;
    send_frame(8'h00, 160, 1'b1, 1'b0);
    send_frame(8'hFF, 160, 1'b1, 1'b0);
    wait_cyc(BIT);
    check("b2b_nvalid", n_valid - v0, 2);
    check("b2b_first", q_at(0), 8'h00);
    check("b2b_second", q_at(1), 8'hFF);
    check("b2b_nferr", n_ferr - f0, 0);

    // Start-bit glitch
    wait_cyc(2 * BIT);
    v0 = n_valid; f0 = n_ferr;
    udata = 1'b0;
    wait_cyc(30);
    check("glitch_busy_hi", busy, 1'b1);
    udata = 1'b1;
    wait_cyc(2 * BIT);
    check("glitch_busy_lo", busy, 1'b0);
    check("glitch_nvalid", n_valid - v0, 0);
    check("glitch_nferr", n_ferr - f0, 0);

    // Framing error after a good byte, then resync on idle
    send_frame(8'h11, 160, 1'b1, 1'b0);
    wait_cyc(BIT);
    v0 = n_valid; f0 = n_ferr;
    send_frame(8'h3C, 160, 1'b0, 1'b0);
    wait_cyc(BIT / 2);
    check("ferr_busy_held", busy, 1'b1);
    wait_cyc(2 * BIT);
    check("ferr_busy_released", busy, 1'b0);
    check("ferr_nferr", n_ferr - f0, 1);
    check("ferr_nvalid", n_valid - v0, 0);
    check("ferr_out_held", out, 8'h11);

    // Reset mid-frame: assert in data bit 3, release in data bit 7 (line low)
    v0 = n_valid; f0 = n_ferr;
    fork
      send_frame(8'h77, 160, 1'b1, 1'b0);
      begin
        wait_cyc(4 * BIT + BIT / 2);
        rst_n = 1'b0;
        wait_cyc(2);
        check("midrst_out", out, 8'h00);
        check("midrst_valid", valid, 1'b0);
        check("midrst_busy", busy, 1'b1);
        wait_cyc(4 * BIT - 2);
        check("midrst_ferr", framing_error, 1'b0);
        rst_n = 1'b1;
      end
    join
    wait_cyc(2 * BIT);
    check("midrst_no_valid", n_valid - v0, 0);
    check("midrst_no_ferr", n_ferr - f0, 0);
    check("midrst_busy_idle", busy, 1'b0);
    send_frame(8'h5A, 160, 1'b1, 1'b0);
    wait_cyc(BIT);
    check("after_rst_nvalid", n_valid - v0, 1);
    check("after_rst_out", out, 8'h5A);

    // Table: spikes, bit-rate skew, framing error
    for (int i = 0; i < 6; i++) begin
      v0 = n_valid; f0 = n_ferr;
      send_frame(vecs[i].data, vecs[i].bl, vecs[i].stop_b, vecs[i].spike);
      wait_cyc(2 * BIT);
      check($sformatf("vec%0d_nvalid", i), n_valid - v0, vecs[i].exp_nvalid);
      check($sformatf("vec%0d_nferr", i), n_ferr - f0, vecs[i].exp_nferr);
      check($sformatf("vec%0d_out", i), out, vecs[i].exp_out);
    end

    // Random frames against a frame-level model
    model_out = vecs[5].exp_out;
    exp_ferr = 0;
    got_q.delete();
    v0 = n_valid; f0 = n_ferr;
    for (int k = 0; k < 14; k++) begin
      logic [7:0] d;
      int         bl;
      logic       sb;
      d  = 8'($urandom_range(0, 255));
      bl = $urandom_range(157, 163);
      sb = ($urandom_range(0, 3) != 0);
      send_frame(d, bl, sb, 1'b0);
      if (sb) begin
        exp_q.push_back(d);
        model_out = d;
        wait_cyc($urandom_range(0, BIT));
      end else begin
        exp_ferr++;
        wait_cyc(2 * BIT + $urandom_range(0, BIT));
      end
    end
    wait_cyc(2 * BIT);
    check("rand_nvalid", n_valid - v0, exp_q.size());
    check("rand_nferr", n_ferr - f0, exp_ferr);
    for (int i = 0; i < exp_q.size(); i++) begin
      check($sformatf("rand_byte%0d", i), q_at(i), exp_q[i]);
    end
    check("rand_out", out, model_out);

    check("valid_ferr_overlap", n_both, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
